// File: rtl/ones_count_datapath.sv
// Datapath for the ones-counter: R1 operand, R2 count, E flip-flop, plus a
// result register that captures R2 when the controller returns to ready.
module ones_count_datapath #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_regs,
  input  logic             incr_r2,
  input  logic             shift,
  input  logic             rdy,
  output logic             zero,
  output logic             E,
  output logic [CW-1:0]    r2,
  output logic [CW-1:0]    result,
  output logic             result_valid
);

  logic [WIDTH-1:0] r1_q, r1_d;
  logic [CW-1:0]    r2_q, r2_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    result_q, result_d;
  logic             valid_q, valid_d;

  always_comb begin
    r1_d     = r1_q;
    r2_d     = r2_q;
    e_d      = e_q;
    busy_d   = busy_q;
    result_d = result_q;
    valid_d  = 1'b0;

    if (load_regs) begin
      // R2 presets to all ones so the controller's first increment yields 0
      r1_d   = data_in;
      r2_d   = '1;
      e_d    = 1'b0;
      busy_d = 1'b1;
    end else begin
      if (incr_r2) begin
        r2_d = r2_q + 1'b1;
      end
      if (shift) begin
        {e_d, r1_d} = {r1_q, 1'b0};
      end
      if (rdy && busy_q) begin
        result_d = r2_q;
        busy_d   = 1'b0;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r1_q     <= '0;
      r2_q     <= '0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      e_q      <= e_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign zero         = (r1_q == '0);
  assign E            = e_q;
  assign r2           = r2_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule
